// File: rtl/demux_1to8_tdm_pkg.sv
// Shared constants and the frame-tracking state type for the 1-to-8 TDM demultiplexer.
package demux_pkg;
  localparam int N_LANES = 8;
  localparam int SEL_W = 3;
  localparam logic [N_LANES-1:0] LANE_MASK_FULL = 8'hFF;

  typedef enum logic {
    S_EMPTY,
    S_FILL
  } state_t;
endpackage

// File: rtl/demux_1to8_tdm_if.sv
// Sample-in / frame-out bundle of the TDM demultiplexer.
interface demux_1to8_tdm_if #(
  parameter int WIDTH = 1
);
  import demux_pkg::*;

  logic                       din_valid;
  logic [WIDTH-1:0]           din;
  logic [SEL_W-1:0]           sel;
  logic                       auto_mode;
  logic                       clear;
  logic [N_LANES*WIDTH-1:0]   y;
  logic                       y_valid;
  logic [N_LANES-1:0]         lane_mask;
  logic [SEL_W-1:0]           slot;
  logic                       overrun;

  modport master (
    output din, din_valid, sel, auto_mode, clear,
    input  y, y_valid, lane_mask, slot, overrun
  );

  modport slave (
    input  din, din_valid, sel, auto_mode, clear,
    output y, y_valid, lane_mask, slot, overrun
  );
endinterface

// File: rtl/demux_1to8_tdm_lane_reg.sv
// One output lane register: async reset, loads d when we is high.
module demux_lane_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

// File: rtl/demux_1to8_tdm.sv
// Registered 1-to-8 TDM demultiplexer: steers samples into lane registers and
// flags frame completion and lane overruns.
//
// state   | meaning
// S_EMPTY | no lane written in the current frame
// S_FILL  | at least one lane written, frame not yet complete
module demux_1to8_tdm
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  demux_1to8_tdm_if.slave bus
);
  state_t                    state, state_next;
  logic [N_LANES-1:0]        lane_mask, mask_next, idx_hot;
  logic [SEL_W-1:0]          slot, slot_next, idx;
  logic                      y_valid_r, y_valid_next;
  logic                      overrun_r, overrun_next;
  logic                      wr;
  logic [N_LANES*WIDTH-1:0]  y_int;

  assign idx     = bus.auto_mode ? slot : bus.sel;
  assign idx_hot = N_LANES'(1) << idx;
  assign wr      = bus.din_valid & ~bus.clear;

  always_comb begin
    state_next   = state;
    mask_next    = lane_mask;
    slot_next    = slot;
    y_valid_next = 1'b0;
    overrun_next = 1'b0;
    if (bus.clear) begin
      mask_next  = '0;
      slot_next  = '0;
      state_next = S_EMPTY;
    end else if (bus.din_valid) begin
      if (bus.auto_mode) slot_next = slot + SEL_W'(1);
      if (lane_mask[idx]) overrun_next = 1'b1;
      if ((lane_mask | idx_hot) == LANE_MASK_FULL) begin
        y_valid_next = 1'b1;
        mask_next    = '0;
        state_next   = S_EMPTY;
      end else begin
        mask_next    = lane_mask | idx_hot;
        state_next   = S_FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      lane_mask <= '0;
      slot      <= '0;
      y_valid_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state     <= state_next;
      lane_mask <= mask_next;
      slot      <= slot_next;
      y_valid_r <= y_valid_next;
      overrun_r <= overrun_next;
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk (clk),
      .rst (rst),
      .we  (wr && (idx == SEL_W'(i))),
      .d   (bus.din),
      .q   (y_int[i*WIDTH +: WIDTH])
    );
  end

  assign bus.y         = y_int;
  assign bus.y_valid   = y_valid_r;
  assign bus.lane_mask = lane_mask;
  assign bus.slot      = slot;
  assign bus.overrun   = overrun_r;
endmodule

// File: tb/tb_demux_1to8_tdm.sv
// Directed bench for demux_1to8_tdm: vector table plus back-to-back and reset sequences.
module tb_demux_1to8_tdm;
  logic clk = 1'b0;
  logic rst = 1'b1;

  demux_1to8_tdm_if #(.WIDTH(1)) bus ();

  demux_1to8_tdm #(.WIDTH(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       din;
    logic       dv;
    logic [2:0] sel;
    logic       am;
    logic       clr;
    logic [7:0] ey;
    logic       eyv;
    logic [7:0] em;
    logic [2:0] es;
    logic       eov;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic din, input logic dv, input logic [2:0] sel, input logic am,
                     input logic clr, input logic [7:0] ey, input logic eyv,
                     input logic [7:0] em, input logic [2:0] es, input logic eov);
    vec_t v;
    v.din = din; v.dv = dv; v.sel = sel; v.am = am; v.clr = clr;
    v.ey = ey; v.eyv = eyv; v.em = em; v.es = es; v.eov = eov;
    vq.push_back(v);
  endtask

  task automatic drive(input logic din, input logic dv, input logic [2:0] sel,
                       input logic am, input logic clr);
    bus.din = din; bus.din_valid = dv; bus.sel = sel; bus.auto_mode = am; bus.clear = clr;
  endtask

  task automatic check_all(input string tag, input logic [7:0] ey, input logic eyv,
                           input logic [7:0] em, input logic [2:0] es, input logic eov);
    chk({tag, ".y"}, 32'(bus.y), 32'(ey));
    chk({tag, ".y_valid"}, 32'(bus.y_valid), 32'(eyv));
    chk({tag, ".lane_mask"}, 32'(bus.lane_mask), 32'(em));
    chk({tag, ".slot"}, 32'(bus.slot), 32'(es));
    chk({tag, ".overrun"}, 32'(bus.overrun), 32'(eov));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f1, f2;
    int pulses, first_c, second_c;
    logic [7:0] y_first, y_second;
    logic saw_ov;

    // din dv sel am clr | y yv mask slot ov
    // auto frame 8'b10111010, LSB first
    add(0,1,0,1,0, 8'h00,0,8'h01,1,0);
    add(1,1,0,1,0, 8'h02,0,8'h03,2,0);
    add(0,1,0,1,0, 8'h02,0,8'h07,3,0);
    add(1,1,0,1,0, 8'h0A,0,8'h0F,4,0);
    add(1,1,0,1,0, 8'h1A,0,8'h1F,5,0);
    add(1,1,0,1,0, 8'h3A,0,8'h3F,6,0);
    add(0,1,0,1,0, 8'h3A,0,8'h7F,7,0);
    add(1,1,0,1,0, 8'hBA,1,8'h00,0,0);
    add(0,0,0,1,0, 8'hBA,0,8'h00,0,0);
    // explicit even lanes, then odd lanes
    add(1,1,0,0,0, 8'hBB,0,8'h01,0,0);
    add(1,1,2,0,0, 8'hBF,0,8'h05,0,0);
    add(1,1,4,0,0, 8'hBF,0,8'h15,0,0);
    add(1,1,6,0,0, 8'hFF,0,8'h55,0,0);
    add(0,1,1,0,0, 8'hFD,0,8'h57,0,0);
    add(0,1,3,0,0, 8'hF5,0,8'h5F,0,0);
    add(0,1,5,0,0, 8'hD5,0,8'h7F,0,0);
    add(0,1,7,0,0, 8'h55,1,8'h00,0,0);
    // overrun on lane 2
    add(1,1,2,0,0, 8'h55,0,8'h04,0,0);
    add(0,1,2,0,0, 8'h51,0,8'h04,0,1);
    add(0,0,2,0,0, 8'h51,0,8'h04,0,0);
    // clear, three auto writes, clear colliding with a write
    add(0,0,0,1,1, 8'h51,0,8'h00,0,0);
    add(0,1,0,1,0, 8'h50,0,8'h01,1,0);
    add(0,1,0,1,0, 8'h50,0,8'h03,2,0);
    add(1,1,0,1,0, 8'h54,0,8'h07,3,0);
    add(1,1,0,1,1, 8'h54,0,8'h00,0,0);
    add(0,0,0,1,0, 8'h54,0,8'h00,0,0);

    drive(0,0,0,0,0);
    #12;
    check_all("reset", 8'h00, 0, 8'h00, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].din, vq[i].dv, vq[i].sel, vq[i].am, vq[i].clr);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vq[i].ey, vq[i].eyv, vq[i].em, vq[i].es, vq[i].eov);
    end

    // back-to-back auto frames with no idle cycle
    f1 = 8'hC3; f2 = 8'h5A;
    pulses = 0; first_c = -1; second_c = -1; y_first = '0; y_second = '0; saw_ov = 1'b0;
    for (int c = 0; c < 18; c++) begin
      if (c < 8)       drive(f1[c], 1, 0, 1, 0);
      else if (c < 16) drive(f2[c-8], 1, 0, 1, 0);
      else             drive(0, 0, 0, 1, 0);
      @(posedge clk); #1;
      if (bus.overrun) saw_ov = 1'b1;
      if (bus.y_valid) begin
        pulses++;
        if (pulses == 1) begin first_c = c; y_first = bus.y; end
        else if (pulses == 2) begin second_c = c; y_second = bus.y; end
      end
    end
    chk("b2b.pulses", 32'(pulses), 32'd2);
    chk("b2b.first_cycle", 32'(first_c), 32'd7);
    chk("b2b.spacing", 32'(second_c - first_c), 32'd8);
    chk("b2b.y_first", 32'(y_first), 32'hC3);
    chk("b2b.y_second", 32'(y_second), 32'h5A);
    chk("b2b.no_overrun", 32'(saw_ov), 32'd0);
    chk("b2b.mask_after", 32'(bus.lane_mask), 32'd0);

    // async reset mid-frame
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 0, 1, 0);
      @(posedge clk); #1;
    end
    check_all("pre_rst", 8'h5F, 0, 8'h07, 3, 0);
    drive(0, 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check_all("mid_rst", 8'h00, 0, 8'h00, 0, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    drive(1, 1, 5, 1, 0);
    @(posedge clk); #1;
    check_all("post_rst", 8'h01, 0, 8'h01, 1, 0);
    drive(0, 0, 0, 1, 0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
